uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive buffer directly downstream of the UART receiver.
- Captures each completed byte on the receiver's one-cycle done tick.
- Stores bytes in a power-of-two circular buffer and presents them to the host side with first-word-fall-through (FWFT) read semantics.
- Reports fill level, almost-full and a sticky overflow flag, so the host can apply software flow control.

Parameters:
- DBIT, 8, data byte width; matches the receiver data width.
- ADDR_W, 4, address width; depth = 2**ADDR_W entries (16).
- AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL. Legal range: 1..2**ADDR_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- wr_tick  in  1  one-cycle write strobe; driven by the receiver done tick.
- wr_data  in  DBIT  received byte; sampled on clk when wr_tick=1.
- rd  in  1  pop request; consumes the head entry.
- ovf_clr  in  1  one-cycle clear of the overflow flag.
- rd_data  out  DBIT  head entry (FWFT); forced to 0 when empty=1.
- empty  out  1  no entries stored.
- full  out  1  count == 2**ADDR_W.
- almost_full  out  1  count >= AF_LEVEL.
- count  out  ADDR_W+1  number of stored entries, 0..2**ADDR_W.
- overflow  out  1  sticky flag: a byte was dropped.

Behaviour:
- Reset (rst=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_full=0, overflow=0, rd_data=0.
  - Storage array is not reset; its contents are discarded logically.
  - Reset asserted mid-operation drops all stored bytes immediately.
- Pointers:
  - wr_ptr and rd_ptr are ADDR_W bits wide and wrap modulo 2**ADDR_W with no special handling.
  - count is tracked explicitly, not derived from the pointers.
- Write (wr_tick=1 and full=0): mem[wr_ptr] <= wr_data; wr_ptr increments.
- Read (rd=1 and empty=0): rd_ptr increments. The head is consumed on that edge.
  - rd=1 while empty=1 is ignored; no state changes and no error flag.
- Simultaneous wr_tick and rd:
  - Not empty and not full: both occur; count unchanged.
  - empty=1: write only; count becomes 1.
  - full=1: read frees a slot and the write is accepted in the same cycle; count stays 2**ADDR_W; no overflow.
- Overflow: wr_tick=1 with full=1 and rd=0.
  - Byte is dropped; pointers and count unchanged; overflow <= 1.
  - overflow stays high until ovf_clr=1.
  - If ovf_clr and a new overflow event occur in the same cycle, set wins (overflow stays 1).
- Latency:
  - All flags (empty, full, almost_full, count) are registered from next-state count and valid the cycle after the causing edge.
  - A byte written on edge N appears on rd_data, with empty=0, after edge N.
  - rd_data is combinational from mem[rd_ptr], gated by empty. Following a pop, rd_data shows the next entry after the same edge.
- Wrap-around: after 2**ADDR_W writes and reads in any interleaving, data order is preserved (strict FIFO).
- Data through the FIFO is bit-exact; no width conversion.

Test Plan:
- Reset, then write 0xA5 via a single wr_tick -> next cycle: empty=0, count=1, rd_data=0xA5. Pulse rd -> empty=1, count=0, rd_data=0x00.
- Write 16 bytes 0x00..0x0F with no reads -> almost_full=1 when count reaches 12; full=1 at count 16. Then read 16 -> rd_data sequence 0x00..0x0F; empty=1 at end.
- Fill FIFO (16 entries), write 0xEE with rd=0 -> overflow=1, count=16, 0xEE never read. Pulse ovf_clr -> overflow=0. ovf_clr together with another dropped write -> overflow stays 1.
- Full FIFO, assert wr_tick(0x77) and rd in the same cycle -> count stays 16, overflow=0, 0x77 read last.
- Write 10, read 10, repeated 5 times with random simultaneous wr/rd -> pointers wrap; read stream equals write stream in order. rd on empty -> no change.
- Hold 5 entries, assert rst=0 asynchronously mid-cycle -> empty=1, count=0, overflow=0 immediately.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through receive buffer between the UART receiver and the host.
// Latency: a byte written on edge N is on rd_data after edge N; the flags are registered from next-state count.
// Backpressure: none toward the receiver; a write into a full buffer with no pop is dropped and sets sticky overflow.
module uart_rx_fifo #(
  parameter int DBIT     = 8,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_tick,
  input  logic [DBIT-1:0]   wr_data,
  input  logic              rd,
  input  logic              ovf_clr,
  output logic [DBIT-1:0]   rd_data,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(1 << ADDR_W);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);

  logic [DBIT-1:0]   mem_q [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              af_q, af_d;
  logic              ovf_q, ovf_d;
  logic              do_wr, do_rd, ovf_set;

  // Next-state: a pop on a full buffer frees the slot the same-cycle write lands in.
  always_comb begin
    do_rd    = rd & ~empty_q;
    do_wr    = wr_tick & (~full_q | do_rd);
    ovf_set  = wr_tick & full_q & ~rd;
    wr_ptr_d = do_wr ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    count_d  = count_q + (ADDR_W+1)'(do_wr) - (ADDR_W+1)'(do_rd);
    empty_d  = (count_d == '0);
    full_d   = (count_d == DEPTH_C);
    af_d     = (count_d >= AF_C);
    // A new drop in the clear cycle keeps the flag set.
    ovf_d    = ovf_set | (ovf_q & ~ovf_clr);
  end

  // Control state; reset discards all stored entries logically.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array; not reset, the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Head entry falls through combinationally, zeroed while empty.
  always_comb begin
    rd_data = empty_q ? '0 : mem_q[rd_ptr_q];
  end

  assign empty       = empty_q;
  assign full        = full_q;
  assign almost_full = af_q;
  assign count       = count_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed stimulus with a byte scoreboard and a per-cycle flag monitor.
module tb_uart_rx_fifo;

  logic       clk;
  logic       rst;
  logic       wr_tick;
  logic [7:0] wr_data;
  logic       rd;
  logic       ovf_clr;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic [4:0] count;
  logic       overflow;

  uart_rx_fifo #(.DBIT(8), .ADDR_W(4), .AF_LEVEL(12)) dut (
    .clk(clk), .rst(rst), .wr_tick(wr_tick), .wr_data(wr_data), .rd(rd),
    .ovf_clr(ovf_clr), .rd_data(rd_data), .empty(empty), .full(full),
    .almost_full(almost_full), .count(count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] sb[$];
  int   mcnt     = 0;
  logic movf     = 1'b0;
  int   exp_cnt  = 0;
  logic exp_ovf  = 1'b0;
  logic mon_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; the reference model predicts acceptance and queues accepted bytes.
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
    logic do_rd, do_wr, ovs;
    @(posedge clk);
    #1;
    wr_tick = w; wr_data = d; rd = r; ovf_clr = c;
    exp_cnt = mcnt;
    exp_ovf = movf;
    do_rd = r && (mcnt != 0);
    do_wr = w && ((mcnt != 16) || do_rd);
    ovs   = w && (mcnt == 16) && !r;
    if (do_wr) sb.push_back(d);
    mcnt = mcnt + (do_wr ? 1 : 0) - (do_rd ? 1 : 0);
    movf = ovs || (movf && !c);
  endtask

  // Monitor: flags against the model every cycle, popped bytes against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      check("count", count, exp_cnt);
      check("empty", empty, (exp_cnt == 0));
      check("full", full, (exp_cnt == 16));
      check("almost_full", almost_full, (exp_cnt >= 12));
      check("overflow", overflow, exp_ovf);
      if (rd && exp_cnt != 0) begin
        if (sb.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL sb_underflow: got byte 0x%0h, expected none queued", rd_data);
        end else begin
          check("rd_data", rd_data, sb.pop_front());
        end
      end else if (exp_cnt == 0) begin
        check("rd_data_empty", rd_data, 8'h00);
      end
    end
  end

  initial begin
    rst = 1'b0; wr_tick = 1'b0; wr_data = 8'h00; rd = 1'b0; ovf_clr = 1'b0;
    #12;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_af", almost_full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_rd_data", rd_data, 8'h00);
    rst = 1'b1;
    mon_en = 1'b1;

    // Single byte in and out.
    step(1, 8'hA5, 0, 0);
    step(0, 8'h00, 0, 0);
    check("a5_empty", empty, 0);
    check("a5_count", count, 1);
    check("a5_data", rd_data, 8'hA5);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);
    check("a5_pop_empty", empty, 1);
    check("a5_pop_count", count, 0);
    check("a5_pop_data", rd_data, 8'h00);

    // Fill 0x00..0x0F, watching almost_full and full thresholds.
    for (int i = 0; i < 16; i++) begin
      step(1, 8'(i), 0, 0);
      if (i == 11) check("af_at_11", almost_full, 0);
      if (i == 12) begin
        check("af_at_12", almost_full, 1);
        check("cnt_at_12", count, 12);
      end
      if (i == 15) check("not_full_15", full, 0);
    end
    step(0, 8'h00, 0, 0);
    check("full_16", full, 1);
    check("cnt_16", count, 16);
    for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);
    check("drain_empty", empty, 1);

    // Overflow: 0xEE dropped, clear, then clear colliding with a new drop.
    for (int i = 0; i < 16; i++) step(1, 8'(8'h30 + i), 0, 0);
    step(1, 8'hEE, 0, 0);
    step(0, 8'h00, 0, 0);
    check("ovf_set", overflow, 1);
    check("ovf_cnt", count, 16);
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 0);
    check("ovf_clr", overflow, 0);
    step(1, 8'hEE, 0, 1);
    step(0, 8'h00, 0, 0);
    check("ovf_set_wins", overflow, 1);

    // Full with simultaneous write and pop: 0x77 accepted, read last.
    step(1, 8'h77, 1, 1);
    step(0, 8'h00, 0, 0);
    check("fullrw_cnt", count, 16);
    check("fullrw_ovf", overflow, 0);
    for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);
    check("fullrw_empty", empty, 1);

    // Read on empty is ignored.
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);
    check("rd_empty_cnt", count, 0);
    check("rd_empty_ovf", overflow, 0);

    // Random interleaving, 5 rounds of 10 bytes; pointers wrap several times.
    for (int round = 0; round < 5; round++) begin
      int wrote = 0;
      while (wrote < 10) begin
        logic w, r;
        w = 1'($urandom_range(0, 1));
        r = 1'($urandom_range(0, 1));
        step(w, 8'((round << 4) | wrote), r, 0);
        if (w) wrote++;
      end
      while (mcnt != 0) step(0, 8'h00, 1, 0);
    end
    step(0, 8'h00, 0, 0);
    check("wrap_empty", empty, 1);

    // Five held entries with overflow set, then asynchronous reset mid-cycle.
    for (int i = 0; i < 17; i++) step(1, 8'(8'hC0 + i), 0, 0);
    for (int i = 0; i < 11; i++) step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);
    check("pre_rst_cnt", count, 5);
    check("pre_rst_ovf", overflow, 1);
    #2;
    mon_en = 1'b0;
    rst = 1'b0;
    #1;
    check("arst_empty", empty, 1);
    check("arst_count", count, 0);
    check("arst_ovf", overflow, 0);
    check("arst_data", rd_data, 8'h00);
    sb.delete();
    mcnt = 0; movf = 1'b0; exp_cnt = 0; exp_ovf = 1'b0;
    wr_tick = 1'b0; rd = 1'b0; ovf_clr = 1'b0;
    #3;
    rst = 1'b1;
    mon_en = 1'b1;

    // Normal operation after reset.
    step(1, 8'h5A, 0, 0);
    step(0, 8'h00, 0, 0);
    check("post_rst_data", rd_data, 8'h5A);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0);
    mon_en = 1'b0;
    check("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
